// File: rtl/demux_lane_sched_if.sv
// Byte-stream and lane-side handshake bundle for demux_lane_sched.
// master: the upstream/lane-sink side (testbench or PHY glue).
// slave:  the scheduler itself.
interface demux_lane_sched_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [3:0]        lane_ready;
  logic [3:0]        out_valid;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        lane_sel;

  modport master (
    output in_valid, in_data, lane_ready,
    input  in_ready, out_valid, out_data, lane_sel
  );

  modport slave (
    input  in_valid, in_data, lane_ready,
    output in_ready, out_valid, out_data, lane_sel
  );
endinterface

// File: rtl/demux_lane_sched.sv
// Round-robin 1x4 byte lane scheduler for the PCIe PHY transmit path.
// One byte is held at a time and is offered to lane lane_sel; a new
// enabled-lane mask only takes effect at a group boundary so that no byte
// group is split across two lane configurations.
// Optional feature: define DEMUX_SCHED_STATS_EN to add saturating
// consumed-byte and stall-cycle counters with a stat_clr strobe.
module demux_lane_sched #(
  parameter int         DATA_W     = 8,
  parameter logic [3:0] RESET_MASK = 4'b1111
`ifdef DEMUX_SCHED_STATS_EN
  , parameter int       STAT_W     = 16
`endif
) (
  input  logic               clk,
  input  logic               reset,
  demux_lane_sched_if.slave  bus,
  input  logic [3:0]         lane_mask_cfg,
  input  logic               cfg_load,
`ifdef DEMUX_SCHED_STATS_EN
  input  logic               stat_clr,
  output logic [STAT_W-1:0]  stat_bytes,
  output logic [STAT_W-1:0]  stat_stalls,
`endif
  output logic [3:0]         active_mask,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, RUN, STALL} state_t;

  // Lowest enabled lane; 0 for an empty mask.
  function automatic logic [1:0] low_lane(input logic [3:0] m);
    low_lane = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (m[i]) low_lane = 2'(i);
  endfunction

  // Highest enabled lane; 0 for an empty mask.
  function automatic logic [1:0] high_lane(input logic [3:0] m);
    high_lane = 2'd0;
    for (int i = 0; i < 4; i++)
      if (m[i]) high_lane = 2'(i);
  endfunction

  // Next enabled lane above sel with 3->0 wrap; sel itself for a single lane.
  // Scanning the largest offset first lets the nearest enabled lane win.
  function automatic logic [1:0] next_lane(input logic [3:0] m, input logic [1:0] sel);
    logic [1:0] idx;
    next_lane = sel;
    for (int k = 3; k >= 1; k--) begin
      idx = sel + 2'(k);
      if (m[idx]) next_lane = idx;
    end
  endfunction

  state_t            state_q;
  logic [3:0]        active_mask_q;
  logic [1:0]        lane_sel_q;
  logic [3:0]        out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic              pend_valid_q;
  logic [3:0]        pend_mask_q;

  logic       held, sel_ready, consume, accept, boundary, apply;
  logic [3:0] cand_mask, mask_next;
  logic [1:0] sel_next;
  logic       in_ready;

  // Handshake, group-boundary detection and next lane/mask selection.
  // A cfg_load in the same cycle overrides the stored pending mask, so a
  // coincident boundary applies the freshly requested value.
  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    held      = |out_valid_q;
    sel_ready = bus.lane_ready[lane_sel_q];
    consume   = held & sel_ready;
    cand_mask = cfg_load ? lane_mask_cfg : pend_mask_q;
    boundary  = (consume & (lane_sel_q == high_lane(active_mask_q))) |
                (!held & (lane_sel_q == low_lane(active_mask_q)));
    apply     = boundary & (cfg_load | pend_valid_q);
    mask_next = apply ? cand_mask : active_mask_q;
    sel_next  = lane_sel_q;
    if (apply)        sel_next = low_lane(cand_mask);
    else if (consume) sel_next = next_lane(active_mask_q, lane_sel_q);
    // A byte cannot be taken in the cycle a zero mask is applied: it would
    // have no lane to go to.
    in_ready  = !reset && (state_q != IDLE) && (!held || sel_ready) &&
                !(apply && (cand_mask == 4'b0000));
    accept    = bus.in_valid & in_ready;
  end

  // Scheduler FSM and all registered outputs. STALL records that the held
  // byte was refused by its lane at the last edge.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= (RESET_MASK == 4'b0000) ? IDLE : RUN;
      active_mask_q <= RESET_MASK;
      lane_sel_q    <= low_lane(RESET_MASK);
      out_valid_q   <= 4'b0000;
      out_data_q    <= '0;
      pend_valid_q  <= 1'b0;
      pend_mask_q   <= 4'b0000;
    end else begin
      active_mask_q <= mask_next;
      lane_sel_q    <= sel_next;

      if (apply) begin
        pend_valid_q <= 1'b0;
      end else if (cfg_load) begin
        pend_valid_q <= 1'b1;
        pend_mask_q  <= lane_mask_cfg;
      end

      if (accept) begin
        out_valid_q <= 4'b0001 << sel_next;
        out_data_q  <= bus.in_data;
      end else if (consume) begin
        out_valid_q <= 4'b0000;
      end

      if (mask_next == 4'b0000)  state_q <= IDLE;
      else if (held && !consume) state_q <= STALL;
      else                       state_q <= RUN;
    end
  end

`ifdef DEMUX_SCHED_STATS_EN
  logic [STAT_W-1:0] stat_bytes_q, stat_stalls_q;

  // Saturating statistics; stat_clr wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (reset || stat_clr) begin
      stat_bytes_q  <= '0;
      stat_stalls_q <= '0;
    end else begin
      if (consume && (stat_bytes_q != '1))
        stat_bytes_q <= stat_bytes_q + 1'b1;
      if (held && !sel_ready && (stat_stalls_q != '1))
        stat_stalls_q <= stat_stalls_q + 1'b1;
    end
  end

  assign stat_bytes  = stat_bytes_q;
  assign stat_stalls = stat_stalls_q;
`endif

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.lane_sel  = lane_sel_q;
  assign active_mask   = active_mask_q;
  assign busy          = (|out_valid_q) | pend_valid_q;

endmodule
